div_two_inputs: RTL and testbench
=================================

# div_two_inputs

Streaming signed 32-bit integer divider for the FM-radio datapath. It pops one dividend from FIFO A and one divisor from FIFO B, and computes the truncating quotient A/B with a 32-step iterative restoring algorithm. It pushes the quotient into a downstream FIFO. It ships with a companion first-word-fall-through `fifo` that provides the input and output buffers.

## Interface
Parameters (div_two_inputs):
- DATA_WIDTH, 32, operand and quotient width

Parameters (fifo):
- FIFO_DATA_WIDTH, 32, word width
- FIFO_BUFFER_SIZE, 256, depth; must be a power of two

Ports (div_two_inputs). One clock; reset is asynchronous and active-low.
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears the FSM, the datapath and all outputs
- inA_rd_en  out  1  pop strobe for the dividend FIFO
- inA_empty  in  1  dividend FIFO empty
- inA_dout  in  32  dividend, signed, FWFT-valid while not empty
- inB_rd_en  out  1  pop strobe for the divisor FIFO
- inB_empty  in  1  divisor FIFO empty
- inB_dout  in  32  divisor, signed
- out_wr_en  out  1  push strobe to the result FIFO
- out_full  in  1  result FIFO full
- out_din  out  32  signed quotient

Ports (fifo). Same clock and reset convention; wr_clk and rd_clk are driven by the same clock.
- reset, wr_clk, wr_en, din[W], full, rd_clk, rd_en, dout[W], empty

## Operation
- **FSM states:** S_READ, S_DIV, S_WRITE.
- **S_READ:**
  - Wait until both inA_empty and inB_empty are 0.
  - In that cycle, assert inA_rd_en and inB_rd_en together for exactly one cycle.
  - Latch the operands and record sign = a[31]^b[31].
  - Latch |a| and |b| as 32-bit unsigned values; |0x80000000| = 0x80000000.
  - Load the iteration counter with 31, then go to S_DIV.
  - Never pop only one of the two FIFOs.
- **S_DIV:**
  - Each cycle performs one restoring step: shift the remainder left and bring in the next dividend MSB.
  - If remainder ≥ |b|, subtract |b| and set the quotient bit.
  - After 32 steps, go to S_WRITE.
- **S_WRITE:**
  - Form the result: q = sign ? -uq : uq, with two's-complement wrap.
  - Hold out_din = q.
  - When out_full = 0, assert out_wr_en for one cycle and return to S_READ.
  - While out_full = 1, keep out_wr_en = 0 and hold out_din.
- **Arithmetic rules:**
  - Truncation toward zero, matching C `/`.
  - Divisor 0 yields quotient 0.
  - 0x80000000 / -1 yields 0x80000000.
- **fifo behaviour:**
  - Circular buffer with separate read and write pointers plus a count.
  - dout = mem[rd_ptr] combinationally, i.e. first-word-fall-through.
  - A write when full is ignored; a read when empty is ignored.
  - Simultaneous read and write keeps the count unchanged.
  - full = (count == SIZE); empty = (count == 0).

## Timing
- **Reset values:**
  - div_two_inputs: state S_READ; inA_rd_en = inB_rd_en = out_wr_en = 0; out_din = 0.
  - fifo: pointers and count 0; empty = 1, full = 0.
- **Latency:**
  - Pop in cycle N.
  - Division steps in cycles N+1 to N+32.
  - out_wr_en in cycle N+33 when not full, giving a quotient visible on fifo dout at N+34.
  - Throughput is one result per 34 cycles.
- **Strobes:** rd_en and wr_en are single-cycle pulses and are never asserted in the same cycle.
- **Reset mid-division:** abandons the operation and emits no partial result. Operands already popped are lost.
- **fifo:** a write at edge N makes the word visible at edge N+1; empty deasserts the cycle after the first write.

## Structure
- **Package div_pkg:** DATA_WIDTH = 32, the state enum (S_READ, S_DIV, S_WRITE), and the constant ITER = 32.
- **Sub-modules:** div_two_inputs has none. `fifo` is the natural standalone companion module; it is instantiated three times around the divider at the system level.

## Test plan
- **Basic signs:** 100/7 → 14; -100/7 → -14; 100/-7 → -14; -100/-7 → 14. Outputs appear in input order with 0 errors against the expected list.
- **Truncation:** -7/2 → -3; 7/-2 → -3; 1/3 → 0.
- **Edge values:**
  - 5/0 → 0.
  - 0x80000000 / -1 → 0x80000000.
  - 0x80000000 / 1 → 0x80000000.
  - 0x7FFFFFFF / 0x7FFFFFFF → 1.
- **Backpressure:**
  - Hold out_full = 1 for 50 cycles after the division completes: out_wr_en stays 0 and out_din is stable.
  - Release out_full: exactly one write occurs, and nothing is lost or duplicated.
- **Operand skew:**
  - Load A with 3 words and B with 1: exactly one quotient is produced; inA_rd_en pulses once and A keeps 2 entries.
- **Reset and FIFO limits:**
  - Deassert-to-active reset in the middle of S_DIV: outputs go to 0 immediately and no write occurs.
  - Fill a fifo with 256 words: full = 1 and a 257th write is ignored; reading all 256 returns them in order, then empty = 1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the streaming signed divider.
package div_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ITER       = 32;
    localparam int CNT_WIDTH  = $clog2(ITER);

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_DIV   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/div_two_inputs_if.sv
// FIFO-side handshake bundle of the divider: two pop ports (dividend, divisor) and one push port.
interface div_two_inputs_if #(
    parameter int DATA_WIDTH = div_pkg::DATA_WIDTH
);

    logic                  inA_rd_en;
    logic                  inA_empty;
    logic [DATA_WIDTH-1:0] inA_dout;

    logic                  inB_rd_en;
    logic                  inB_empty;
    logic [DATA_WIDTH-1:0] inB_dout;

    logic                  out_wr_en;
    logic                  out_full;
    logic [DATA_WIDTH-1:0] out_din;

    // Divider side.
    modport master (
        output inA_rd_en,
        input  inA_empty,
        input  inA_dout,
        output inB_rd_en,
        input  inB_empty,
        input  inB_dout,
        output out_wr_en,
        input  out_full,
        output out_din
    );

    // FIFO side.
    modport slave (
        input  inA_rd_en,
        output inA_empty,
        output inA_dout,
        input  inB_rd_en,
        output inB_empty,
        output inB_dout,
        input  out_wr_en,
        output out_full,
        input  out_din
    );

endinterface

// File: rtl/fifo.sv
// First-word-fall-through circular FIFO; wr_clk and rd_clk are expected to be the same clock.
module fifo #(
    parameter int FIFO_DATA_WIDTH  = 32,
    parameter int FIFO_BUFFER_SIZE = 256
) (
    input  logic                       reset,
    input  logic                       wr_clk,
    input  logic                       wr_en,
    input  logic [FIFO_DATA_WIDTH-1:0] din,
    output logic                       full,
    input  logic                       rd_clk,
    input  logic                       rd_en,
    output logic [FIFO_DATA_WIDTH-1:0] dout,
    output logic                       empty
);

    localparam int ADDR_WIDTH = $clog2(FIFO_BUFFER_SIZE);
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CAPACITY = (ADDR_WIDTH+1)'(FIFO_BUFFER_SIZE);

    logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_BUFFER_SIZE];

    // Pointers carry one extra wrap bit so the count falls out of their difference.
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] count;
    logic                do_wr;
    logic                do_rd;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == CAPACITY);
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem[rd_ptr[ADDR_WIDTH-1:0]];

    // NOTE: the storage array is deliberately not reset; the pointers alone define which words are valid.
    always_ff @(posedge wr_clk) begin
        if (do_wr) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
        end
    end

    always_ff @(posedge wr_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
        end else if (do_wr) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge rd_clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
        end else if (do_rd) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/div_two_inputs.sv
// Streaming signed divider: pops a dividend and a divisor together, runs a 32-step restoring
// division on the magnitudes, then pushes the sign-corrected truncating quotient.
module div_two_inputs #(
    parameter int DATA_WIDTH = div_pkg::DATA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    div_two_inputs_if.master bus
);

    localparam int CW = div_pkg::CNT_WIDTH;
    localparam logic [CW-1:0] CNT_LOAD = CW'(div_pkg::ITER - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    div_pkg::state_t state;

    logic                  sign;
    logic                  div_zero;
    logic [DATA_WIDTH-1:0] abs_b;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] qd;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] out_q;

    logic                  start;
    logic [DATA_WIDTH:0]   trial;
    logic                  take;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0] qd_next;
    logic [DATA_WIDTH-1:0] quot;

    // Both operands must be present so the two input FIFOs always stay in step.
    assign start         = (state == div_pkg::S_READ) && !bus.inA_empty && !bus.inB_empty;
    assign bus.inA_rd_en = start;
    assign bus.inB_rd_en = start;
    assign bus.out_wr_en = (state == div_pkg::S_WRITE) && !bus.out_full;
    assign bus.out_din   = out_q;

    // qd starts as |a| and shifts out dividend bits at the top while quotient bits enter at the bottom.
    // NOTE: every always_comb output gets an unconditional assignment so no latch can be inferred.
    always_comb begin
        trial    = {rem, qd[DATA_WIDTH-1]};
        take     = (trial >= {1'b0, abs_b});
        rem_next = take ? (trial[DATA_WIDTH-1:0] - abs_b) : trial[DATA_WIDTH-1:0];
        qd_next  = {qd[DATA_WIDTH-2:0], take};
        quot     = div_zero ? '0 : (sign ? -qd_next : qd_next);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= div_pkg::S_READ;
            sign     <= 1'b0;
            div_zero <= 1'b0;
            abs_b    <= '0;
            rem      <= '0;
            qd       <= '0;
            cnt      <= '0;
            out_q    <= '0;
        end else begin
            case (state)
                div_pkg::S_READ: begin
                    if (start) begin
                        sign     <= bus.inA_dout[DATA_WIDTH-1] ^ bus.inB_dout[DATA_WIDTH-1];
                        div_zero <= (bus.inB_dout == '0);
                        qd       <= bus.inA_dout[DATA_WIDTH-1] ? -bus.inA_dout : bus.inA_dout;
                        abs_b    <= bus.inB_dout[DATA_WIDTH-1] ? -bus.inB_dout : bus.inB_dout;
                        rem      <= '0;
                        cnt      <= CNT_LOAD;
                        state    <= div_pkg::S_DIV;
                    end
                end
                div_pkg::S_DIV: begin
                    rem <= rem_next;
                    qd  <= qd_next;
                    if (cnt == '0) begin
                        out_q <= quot;
                        state <= div_pkg::S_WRITE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                div_pkg::S_WRITE: begin
                    if (!bus.out_full) begin
                        state <= div_pkg::S_READ;
                    end
                end
                default: state <= div_pkg::S_READ;
            endcase
        end
    end

    a_strobes_exclusive: assert property (@(posedge clock) disable iff (!reset)
        !((bus.inA_rd_en || bus.inB_rd_en) && bus.out_wr_en));

endmodule

// File: tb/tb_div_two_inputs.sv
// Scoreboard bench: divider wrapped by its three FIFOs plus a standalone FIFO for depth tests.
module tb_div_two_inputs;

    localparam int W     = 32;
    localparam int DEPTH = 256;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    div_two_inputs_if #(.DATA_WIDTH(W)) bus ();

    logic         a_wr_en = 1'b0, b_wr_en = 1'b0;
    logic [W-1:0] a_din = '0, b_din = '0;
    logic         a_full, b_full, a_empty, b_empty;
    logic [W-1:0] a_dout, b_dout;
    logic         o_full, o_empty;
    logic [W-1:0] o_dout;
    logic         o_rd_en = 1'b1;
    logic         hold_full = 1'b0;

    logic         t_wr_en = 1'b0, t_rd_en = 1'b0;
    logic [W-1:0] t_din = '0;
    logic         t_full, t_empty;
    logic [W-1:0] t_dout;

    fifo #(.FIFO_DATA_WIDTH(W), .FIFO_BUFFER_SIZE(DEPTH)) fifo_a (
        .reset(reset), .wr_clk(clock), .wr_en(a_wr_en), .din(a_din), .full(a_full),
        .rd_clk(clock), .rd_en(bus.inA_rd_en), .dout(a_dout), .empty(a_empty));
    fifo #(.FIFO_DATA_WIDTH(W), .FIFO_BUFFER_SIZE(DEPTH)) fifo_b (
        .reset(reset), .wr_clk(clock), .wr_en(b_wr_en), .din(b_din), .full(b_full),
        .rd_clk(clock), .rd_en(bus.inB_rd_en), .dout(b_dout), .empty(b_empty));
    fifo #(.FIFO_DATA_WIDTH(W), .FIFO_BUFFER_SIZE(DEPTH)) fifo_o (
        .reset(reset), .wr_clk(clock), .wr_en(bus.out_wr_en), .din(bus.out_din), .full(o_full),
        .rd_clk(clock), .rd_en(o_rd_en), .dout(o_dout), .empty(o_empty));
    fifo #(.FIFO_DATA_WIDTH(W), .FIFO_BUFFER_SIZE(DEPTH)) fifo_t (
        .reset(reset), .wr_clk(clock), .wr_en(t_wr_en), .din(t_din), .full(t_full),
        .rd_clk(clock), .rd_en(t_rd_en), .dout(t_dout), .empty(t_empty));

    assign bus.inA_empty = a_empty;
    assign bus.inA_dout  = a_dout;
    assign bus.inB_empty = b_empty;
    assign bus.inB_dout  = b_dout;
    assign bus.out_full  = o_full | hold_full;

    div_two_inputs #(.DATA_WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return '0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
    endfunction

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_out[$];

    int cyc = 0, rd_cyc = 0, wr_cyc = 0, wr_gap = 0;
    int rda_cnt = 0, rdb_cnt = 0, wr_cnt = 0;
    int pair_bad = 0, overlap_bad = 0, extra_wr = 0, extra_out = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Divider-side monitor: pops the scoreboard on every accepted write.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.inA_rd_en) begin
                rda_cnt <= rda_cnt + 1;
                rd_cyc  <= cyc;
            end
            if (bus.inB_rd_en) rdb_cnt <= rdb_cnt + 1;
            if (bus.inA_rd_en !== bus.inB_rd_en) pair_bad <= pair_bad + 1;
            if (bus.out_wr_en && (bus.inA_rd_en || bus.inB_rd_en)) overlap_bad <= overlap_bad + 1;
            if (bus.out_wr_en) begin
                wr_cnt <= wr_cnt + 1;
                wr_gap <= cyc - wr_cyc;
                wr_cyc <= cyc;
                if (exp_q.size() == 0) begin
                    extra_wr <= extra_wr + 1;
                end else begin
                    check("quotient", bus.out_din, exp_q[0]);
                    exp_out.push_back(exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Result FIFO is drained every cycle; its head must follow the same order.
    always @(negedge clock) begin
        if (reset && !o_empty) begin
            if (exp_out.size() == 0) begin
                extra_out <= extra_out + 1;
            end else begin
                check("fifo_out", o_dout, exp_out[0]);
                void'(exp_out.pop_front());
            end
        end
    end

    task automatic drive(input logic wa, input logic [W-1:0] a, input logic wb, input logic [W-1:0] b);
        @(posedge clock); #1;
        a_wr_en = wa; a_din = a;
        b_wr_en = wb; b_din = b;
        @(posedge clock); #1;
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_q.push_back(ref_div(a, b));
        drive(1'b1, a, 1'b1, b);
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            @(posedge clock);
            n++;
        end
        check("write_count", wr_cnt, target);
    endtask

    initial begin
        int total;
        int r0;
        int w0;
        int n;
        int bp_bad;
        logic [W-1:0] d0;

        total = 0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_rd_a", 32'(bus.inA_rd_en), 0);
        check("rst_rd_b", 32'(bus.inB_rd_en), 0);
        check("rst_wr", 32'(bus.out_wr_en), 0);
        check("rst_din", bus.out_din, 0);
        check("rst_fifo_empty", 32'(t_empty), 1);
        check("rst_fifo_full", 32'(t_full), 0);
        reset = 1'b1;

        // Basic signs, queued back to back.
        push_pair(32'sd100, 32'sd7);
        push_pair(-32'sd100, 32'sd7);
        push_pair(32'sd100, -32'sd7);
        push_pair(-32'sd100, -32'sd7);
        total += 4;
        wait_writes(total, 200);
        check("latency", wr_cyc - rd_cyc, 33);
        check("throughput", wr_gap, 34);

        // Truncation and edge values.
        push_pair(-32'sd7, 32'sd2);
        push_pair(32'sd7, -32'sd2);
        push_pair(32'sd1, 32'sd3);
        push_pair(32'sd5, 32'sd0);
        push_pair(32'h8000_0000, 32'hFFFF_FFFF);
        push_pair(32'h8000_0000, 32'sd1);
        push_pair(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        total += 7;
        wait_writes(total, 350);

        // Backpressure: quotient held for 50 cycles, then exactly one write.
        @(posedge clock); #1;
        hold_full = 1'b1;
        push_pair(32'sd1000, 32'sd10);
        total += 1;
        repeat (40) @(posedge clock);
        #1;
        d0 = bus.out_din;
        check("bp_value", d0, 100);
        w0 = wr_cnt;
        bp_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            if (bus.out_wr_en || bus.out_din !== d0) bp_bad++;
        end
        check("bp_hold", bp_bad, 0);
        hold_full = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("bp_one_write", wr_cnt, w0 + 1);

        // Operand skew: three dividends, one divisor.
        r0 = rda_cnt;
        drive(1'b1, 32'sd30, 1'b0, 32'sd0);
        drive(1'b1, 32'sd60, 1'b0, 32'sd0);
        drive(1'b1, 32'sd90, 1'b0, 32'sd0);
        exp_q.push_back(32'sd10);
        drive(1'b0, 32'sd0, 1'b1, 32'sd3);
        total += 1;
        wait_writes(total, 100);
        repeat (40) @(posedge clock);
        #1;
        check("skew_pops", rda_cnt - r0, 1);
        check("skew_writes", wr_cnt, total);
        check("skew_a_left", 32'(a_empty), 0);
        exp_q.push_back(32'sd20);
        drive(1'b0, 32'sd0, 1'b1, 32'sd3);
        exp_q.push_back(32'sd30);
        drive(1'b0, 32'sd0, 1'b1, 32'sd3);
        total += 2;
        wait_writes(total, 150);
        #1;
        check("skew_a_drained", 32'(a_empty), 1);
        repeat (5) @(posedge clock);

        // Reset in the middle of a division: no result may escape.
        r0 = rda_cnt;
        drive(1'b1, 32'sd12345, 1'b1, 32'sd7);
        n = 0;
        while (rda_cnt == r0 && n < 50) begin
            @(posedge clock);
            n++;
        end
        check("mid_pop", rda_cnt, r0 + 1);
        repeat (10) @(posedge clock);
        #1;
        w0 = wr_cnt;
        reset = 1'b0;
        #1;
        check("mid_rst_din", bus.out_din, 0);
        check("mid_rst_wr", 32'(bus.out_wr_en), 0);
        check("mid_rst_rd", 32'(bus.inA_rd_en), 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (60) @(posedge clock);
        #1;
        check("mid_no_write", wr_cnt, w0);

        // Standalone FIFO: fill, overflow attempt, ordered drain.
        check("fifo_empty_init", 32'(t_empty), 1);
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clock); #1;
            if (i == 1) check("fifo_empty_after_first", 32'(t_empty), 0);
            t_wr_en = 1'b1;
            t_din   = 32'(i * 3 + 1);
        end
        @(posedge clock); #1;
        check("fifo_full", 32'(t_full), 1);
        t_din = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        t_wr_en = 1'b0;
        check("fifo_full_after_extra", 32'(t_full), 1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) begin
                @(posedge clock); #1;
            end
            check("fifo_order", t_dout, 32'(i * 3 + 1));
            t_rd_en = 1'b1;
        end
        @(posedge clock); #1;
        t_rd_en = 1'b0;
        check("fifo_empty_end", 32'(t_empty), 1);
        check("fifo_not_full_end", 32'(t_full), 0);

        repeat (5) @(posedge clock);
        #1;
        check("pair_pops", pair_bad, 0);
        check("pop_counts", rda_cnt, rdb_cnt);
        check("strobe_overlap", overlap_bad, 0);
        check("extra_writes", extra_wr, 0);
        check("extra_fifo_out", extra_out, 0);
        check("sb_left", exp_q.size(), 0);
        check("sb_out_left", exp_out.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
